// File: rtl/pwmdir_capture.sv
// pwmdir_capture: measures PWM period and DIR-signed high time, with loss-of-signal timeout.
// Define PWMDIR_CAPTURE_FILTER_EN to add a filter_len-sample glitch filter on both pins.
module pwmdir_capture #(
  parameter int unsigned timeout_cycles = 1000000,
  parameter int unsigned filter_len = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PWM,
  input  logic               DIR,
  output logic [31:0]        pwmPeriod,
  output logic signed [31:0] pwmWidth,
  output logic               pwmValid,
  output logic               pwmActive
);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t      state_q;
  logic [1:0]  pwm_sync_q, dir_sync_q;
  logic        pwm_s, dir_s, pwm_d_q, rise;
  logic [31:0] period_cnt_q, high_cnt_q, period_q, width_q;
  logic        valid_q, active_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      pwm_sync_q <= '0;
      dir_sync_q <= '0;
    end else begin
      pwm_sync_q <= {pwm_sync_q[0], PWM};
      dir_sync_q <= {dir_sync_q[0], DIR};
    end
`ifdef PWMDIR_CAPTURE_FILTER_EN
  localparam int unsigned CW = $clog2(filter_len + 1);
  logic [1:0] raw, filt;
  assign raw = {dir_sync_q[1], pwm_sync_q[1]};
  for (genvar i = 0; i < 2; i++) begin : g_filt
    logic          f_q;
    logic [CW-1:0] cnt_q;
    // cnt_q counts consecutive samples that disagree with the filtered level
    always_ff @(posedge clk)
      if (!rst_n) begin
        f_q   <= 1'b0;
        cnt_q <= '0;
      end else if (raw[i] == f_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(filter_len - 1)) begin
        f_q   <= raw[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    assign filt[i] = f_q;
  end
  assign pwm_s = filt[0];
  assign dir_s = filt[1];
`else
  logic unused_filter;
  assign unused_filter = (filter_len > 0);
  assign pwm_s = pwm_sync_q[1];
  assign dir_s = dir_sync_q[1];
`endif
  assign rise = pwm_s & ~pwm_d_q;
  // An edge closing a period takes priority over the timeout in the same cycle
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q      <= IDLE;
      pwm_d_q      <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      width_q      <= '0;
      valid_q      <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      pwm_d_q <= pwm_s;
      valid_q <= 1'b0;
      if (rise) begin
        state_q      <= MEASURE;
        period_cnt_q <= 32'd1;
        high_cnt_q   <= 32'd1;
        if (state_q == MEASURE) begin
          period_q <= period_cnt_q;
          width_q  <= dir_s ? high_cnt_q : -high_cnt_q;
          valid_q  <= 1'b1;
          active_q <= 1'b1;
        end
      end else if (state_q == MEASURE) begin
        if (period_cnt_q == 32'(timeout_cycles)) begin
          state_q      <= IDLE;
          period_cnt_q <= '0;
          high_cnt_q   <= '0;
          period_q     <= '0;
          width_q      <= '0;
          active_q     <= 1'b0;
        end else begin
          period_cnt_q <= period_cnt_q + 32'd1;
          high_cnt_q   <= pwm_s ? high_cnt_q + 32'd1 : high_cnt_q;
        end
      end
    end
  assign pwmPeriod = period_q;
  assign pwmWidth  = width_q;
  assign pwmValid  = valid_q;
  assign pwmActive = active_q;
endmodule

// File: tb/tb_pwmdir_capture.sv
// tb_pwmdir_capture: two DUTs (timeout 200 and 100) checked every cycle against a sample-queue model.
module tb_pwmdir_capture;
  logic clk = 1'b0, rst_n = 1'b0, PWM = 1'b0, DIR = 1'b0;
  logic [31:0] per [2];
  logic [31:0] wid [2];
  logic        val [2];
  logic        act [2];
  int errors = 0, checks = 0, cyc = 0;
  int nval_a = 0, first_valid = -1, fall_cyc = -1, last_rise = 0, j0 = 0;
  bit prev_act_a = 0, started = 0;
  int          T [2] = '{200, 100};
  bit          trk [2];
  int          q [2][$];
  logic [31:0] ep [2];
  logic [31:0] ew [2];
  logic        ev [2];
  logic        ea [2];
  bit [2:0]    hp, hd;
  always #5 clk = ~clk;
  pwmdir_capture #(.timeout_cycles(200)) dut_a (
    .clk(clk), .rst_n(rst_n), .PWM(PWM), .DIR(DIR),
    .pwmPeriod(per[0]), .pwmWidth(wid[0]), .pwmValid(val[0]), .pwmActive(act[0]));
  pwmdir_capture #(.timeout_cycles(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .PWM(PWM), .DIR(DIR),
    .pwmPeriod(per[1]), .pwmWidth(wid[1]), .pwmValid(val[1]), .pwmActive(act[1]));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", n, cyc, a, e);
    end
  endtask
  // Model: each period is a queue of pin-high samples between two edges, seen two clocks late
  always @(posedge clk) begin
    bit x, d, r;
    int s;
    cyc = cyc + 1;
    if (!rst_n) begin
      started = 1;
      hp = '0;
      hd = '0;
      for (int i = 0; i < 2; i++) begin
        trk[i] = 0; q[i].delete(); ep[i] = 0; ew[i] = 0; ev[i] = 0; ea[i] = 0;
      end
    end else begin
      x = hp[1];
      d = hd[1];
      r = hp[1] & ~hp[2];
      hp = {hp[1:0], PWM};
      hd = {hd[1:0], DIR};
      for (int i = 0; i < 2; i++) begin
        ev[i] = 0;
        if (r) begin
          if (trk[i]) begin
            s = 0;
            for (int k = 0; k < q[i].size(); k++) s += q[i][k];
            ep[i] = 32'(q[i].size());
            ew[i] = d ? 32'(s) : -32'(s);
            ev[i] = 1;
            ea[i] = 1;
          end
          trk[i] = 1;
          q[i].delete();
          q[i].push_back(1);
        end else if (trk[i]) begin
          if (q[i].size() == T[i]) begin
            trk[i] = 0; q[i].delete(); ep[i] = 0; ew[i] = 0; ea[i] = 0;
          end else begin
            q[i].push_back(int'(x));
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    if (started)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("period%0d", i), per[i], ep[i]);
        chk($sformatf("width%0d", i), wid[i], ew[i]);
        chk($sformatf("valid%0d", i), 32'(val[i]), 32'(ev[i]));
        chk($sformatf("active%0d", i), 32'(act[i]), 32'(ea[i]));
      end
    if (val[0]) begin
      nval_a++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (prev_act_a && !act[0]) fall_cyc = cyc;
    prev_act_a = act[0];
  end
  task automatic drive(input bit p, input bit d);
    @(negedge clk);
    PWM = p;
    DIR = d;
  endtask
  task automatic period(input int P, input int H, input bit d0, input bit d1, input int mid, input int g);
    for (int c = 0; c < P; c++) begin
      drive((c < H) || (g > 0 && (c == g || c == g + 1)), c < mid ? d0 : d1);
      if (c == 0 && H > 0) last_rise = cyc;
    end
  endtask
  task automatic hold(input bit p, input int n);
    repeat (n) drive(p, DIR);
  endtask
  initial begin
    for (int i = 0; i < 5; i++) drive(i[0], 1'b1);
    chk("rst_period", per[0], 32'd0);
    chk("rst_width", wid[0], 32'd0);
    chk("rst_valid", 32'(val[0]), 32'd0);
    chk("rst_active", 32'(act[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    PWM = 1'b0;
    hold(1'b0, 3);
    nval_a = 0;
    period(100, 30, 1, 1, 100, 0);
    j0 = last_rise;
    repeat (4) period(100, 30, 1, 1, 100, 0);
    chk("first_strobe_cycle", 32'(first_valid), 32'(j0 + 103));
    chk("pos_strobes", 32'(nval_a), 32'd4);
    chk("pos_period", per[0], 32'd100);
    chk("pos_width", wid[0], 32'd30);
    chk("pos_active", 32'(act[0]), 32'd1);
    chk("race_period", per[1], 32'd100);
    chk("race_active", 32'(act[1]), 32'd1);
    repeat (3) period(100, 30, 0, 0, 100, 0);
    chk("neg_width", wid[0], 32'hFFFFFFE2);
    chk("neg_period", per[0], 32'd100);
    period(100, 30, 0, 1, 15, 0);
    period(100, 30, 1, 1, 100, 0);
    chk("dir_mid_width", wid[0], 32'd30);
    repeat (3) period(50, 1, 0, 0, 50, 0);
    chk("pulse1_width", wid[0], 32'hFFFFFFFF);
    chk("pulse1_period", per[0], 32'd50);
    fall_cyc = -1;
    hold(1'b0, 250);
    chk("timeout_cycle", 32'(fall_cyc), 32'(last_rise + 203));
    chk("tlow_period", per[0], 32'd0);
    chk("tlow_width", wid[0], 32'd0);
    chk("tlow_active", 32'(act[0]), 32'd0);
    nval_a = 0;
    repeat (3) period(100, 30, 1, 1, 100, 0);
    chk("restart_strobes", 32'(nval_a), 32'd2);
    hold(1'b1, 250);
    chk("thigh_width", wid[0], 32'd0);
    chk("thigh_active", 32'(act[0]), 32'd0);
    hold(1'b0, 5);
    nval_a = 0;
    repeat (3) period(100, 30, 1, 1, 100, 60);
    period(20, 1, 1, 1, 20, 0);
    chk("glitch_strobes", 32'(nval_a), 32'd6);
    chk("glitch_period", per[0], 32'd40);
    chk("glitch_width", wid[0], 32'd2);
    chk("glitch_active", 32'(act[0]), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
